// File: rtl/fp_norm_round_pipe_pkg.sv
// Shared widths and helpers for the FP normalise/round pipeline.
// Default widths, all-ones exponent value and clog2.
package fp_norm_round_pipe_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 24;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int exp_max(input int ew);
    return (1 << ew) - 1;
  endfunction

endpackage

// File: rtl/fp_norm_round_pipe_lzc.sv
// Combinational leading-zero counter, MSB-first.
// Ports: i_data [W-1:0] in, o_cnt [clog2(W+1)-1:0] out (all-zero gives W).
module fp_lzc
  import fp_norm_round_pipe_pkg::*;
#(
  parameter int W = 26
) (
  input  logic [W-1:0]            i_data,
  output logic [clog2(W+1)-1:0]   o_cnt
);

  localparam int CW = clog2(W + 1);

  // Later (higher) set bits overwrite earlier ones, so the MSB wins.
  always_comb begin
    o_cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (i_data[i]) o_cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_round_pipe.sv
// Two-stage normaliser + RNE rounder for the FP add datapath.
// Ports: CLK/RST, in_* beat with valid/ready, out_* result with valid/ready and ovf/unf/zero flags.
module fp_norm_round_pipe
  import fp_norm_round_pipe_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_carry,
  input  logic [MAN_W+1:0] in_man,
  input  logic             in_sticky,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_man,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             out_zero
);

  localparam int MW2 = MAN_W + 2;
  localparam int EW2 = EXP_W + 2;
  localparam int LZW = clog2(MW2 + 1);
  localparam logic signed [EW2-1:0] E_ONE = EW2'(1);
  localparam logic signed [EW2-1:0] E_MAX = EW2'(exp_max(EXP_W));

  logic w_en1;
  logic w_en2;

  logic                  r1_v;
  logic                  r1_sign;
  logic signed [EW2-1:0] r1_e;
  logic [MW2-1:0]        r1_n;
  logic                  r1_s;
  logic                  r1_zero;
  logic                  r1_unf;

  logic             r2_v;
  logic             r2_sign;
  logic [EXP_W-1:0] r2_exp;
  logic [MAN_W-1:0] r2_man;
  logic             r2_ovf;
  logic             r2_unf;
  logic             r2_zero;

  assign w_en2     = out_ready | ~r2_v;
  assign w_en1     = w_en2 | ~r1_v;
  assign in_ready  = w_en1;
  assign out_valid = r2_v;
  assign out_sign  = r2_sign;
  assign out_exp   = r2_exp;
  assign out_man   = r2_man;
  assign out_ovf   = r2_ovf;
  assign out_unf   = r2_unf;
  assign out_zero  = r2_zero;

  // Stage 1: normalise
  logic [LZW-1:0]        w_lz;
  logic signed [EW2-1:0] w_e_in;
  logic signed [EW2-1:0] w_e_sub;
  logic                  w_sel_c;
  logic                  w_sel_z;
  logic                  w_sel_u;
  logic                  w_sel_n;
  logic [MW2-1:0]        w_n;
  logic signed [EW2-1:0] w_e;
  logic                  w_s;
  logic                  w_zero;
  logic                  w_unf;

  fp_lzc #(.W(MW2)) u_lzc (
    .i_data (in_man),
    .o_cnt  (w_lz)
  );

  assign w_e_in  = {2'b00, in_exp};
  assign w_e_sub = w_e_in - {{(EW2-LZW){1'b0}}, w_lz};

  // Selects made mutually exclusive so exactly one arm fires.
  assign w_sel_c = in_carry;
  assign w_sel_z = ~in_carry & ~|in_man & ~in_sticky;
  assign w_sel_u = ~in_carry & ~w_sel_z & (w_e_sub < E_ONE);
  assign w_sel_n = ~(w_sel_c | w_sel_z | w_sel_u);

  always_comb begin
    w_n    = '0;
    w_e    = '0;
    w_s    = 1'b0;
    w_zero = 1'b0;
    w_unf  = 1'b0;
    unique case (1'b1)
      w_sel_c: begin
        w_n = {1'b1, in_man[MW2-1:1]};
        w_s = in_sticky | in_man[0];
        w_e = w_e_in + E_ONE;
      end
      w_sel_z: begin
        w_zero = 1'b1;
      end
      w_sel_u: begin
        w_unf  = 1'b1;
        w_zero = 1'b1;
      end
      w_sel_n: begin
        w_n = in_man << w_lz;
        w_e = w_e_sub;
        w_s = in_sticky;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r1_v    <= 1'b0;
      r1_sign <= 1'b0;
      r1_e    <= '0;
      r1_n    <= '0;
      r1_s    <= 1'b0;
      r1_zero <= 1'b0;
      r1_unf  <= 1'b0;
    end else if (w_en1) begin
      r1_v    <= in_valid;
      r1_sign <= in_sign;
      r1_e    <= w_e;
      r1_n    <= w_n;
      r1_s    <= w_s;
      r1_zero <= w_zero;
      r1_unf  <= w_unf;
    end
  end

  // Stage 2: round to nearest even
  logic                  w_up;
  logic [MAN_W:0]        w_sum;
  logic [MAN_W-1:0]      w_man;
  logic signed [EW2-1:0] w_e2;
  logic                  w_ovf;

  assign w_up  = r1_n[1] & (r1_n[0] | r1_s | r1_n[2]);
  assign w_sum = {1'b0, r1_n[MW2-1:2]} + {{MAN_W{1'b0}}, w_up};

  // Carry out of the increment means the mantissa wrapped to zero.
  always_comb begin
    if (w_sum[MAN_W]) begin
      w_man = {1'b1, {(MAN_W-1){1'b0}}};
      w_e2  = r1_e + E_ONE;
    end else begin
      w_man = w_sum[MAN_W-1:0];
      w_e2  = r1_e;
    end
  end

  assign w_ovf = ~r1_zero & (w_e2 >= E_MAX);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r2_v    <= 1'b0;
      r2_sign <= 1'b0;
      r2_exp  <= '0;
      r2_man  <= '0;
      r2_ovf  <= 1'b0;
      r2_unf  <= 1'b0;
      r2_zero <= 1'b0;
    end else if (w_en2) begin
      r2_v    <= r1_v;
      r2_sign <= r1_sign;
      if (r1_zero) begin
        r2_exp  <= '0;
        r2_man  <= '0;
        r2_ovf  <= 1'b0;
        r2_unf  <= r1_unf;
        r2_zero <= 1'b1;
      end else if (w_ovf) begin
        r2_exp  <= '1;
        r2_man  <= '0;
        r2_ovf  <= 1'b1;
        r2_unf  <= 1'b0;
        r2_zero <= 1'b0;
      end else begin
        r2_exp  <= w_e2[EXP_W-1:0];
        r2_man  <= w_man;
        r2_ovf  <= 1'b0;
        r2_unf  <= 1'b0;
        r2_zero <= 1'b0;
      end
    end
  end

endmodule
